id_scoreboard: RTL and testbench

- Parametrised successor to the ID-stage hazard detector and ID forwarding logic.
- Tracks every in-flight register write with a per-register age/latency entry, instead of comparing against fixed EX/MEM ports.
- Drives stall/bubble and a per-operand forward-stage select for any forwarding depth and producer latency (ALU=1, load=2, multi-cycle units up to FWD_STAGES).
- Sits beside the register file in ID; the datapath muxes forward data by stage index.

---
 rtl/id_pkg.sv | 14 +
 rtl/id_sb_entry.sv | 56 +++++
 rtl/id_scoreboard.sv | 154 +++++++++++++++
 tb/tb_id_scoreboard.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg: constants shared by the ID-stage scoreboard.
//   REG_AW           default register index width
//   FWD_SEL_REGFILE  forward-select value meaning "take operand from regfile"
//   FWD_EX / FWD_MEM forward-select stage indices for the EX and MEM results
// ---------------------------------------------------------------------------
package id_pkg;

    localparam int REG_AW          = 5;
    localparam int FWD_SEL_REGFILE = 0;
    localparam int FWD_EX          = 1;
    localparam int FWD_MEM         = 2;

endpackage : id_pkg

// File: rtl/id_sb_entry.sv
// ---------------------------------------------------------------------------
// id_sb_entry: busy/age/latency state for one architectural register.
//   clk, reset  clock and synchronous active-high reset
//   issue       a new producer of this register leaves ID this cycle
//   lat_in      clamped stage at which the new producer's result is forwardable
//   busy        an in-flight write to this register exists
//   age         stage the youngest producer currently occupies (1 = EX)
//   lat         stage at which that producer's result becomes forwardable
// ---------------------------------------------------------------------------
module id_sb_entry
    import id_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int AGE_W      = $clog2(FWD_STAGES + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic [AGE_W-1:0] lat_in,
    output logic             busy,
    output logic [AGE_W-1:0] age,
    output logic [AGE_W-1:0] lat
);

    logic             busy_r;
    logic [AGE_W-1:0] age_r;
    logic [AGE_W-1:0] lat_r;

    // Entry state: a fresh issue always wins over retirement so the youngest
    // producer is tracked; otherwise the producer moves one stage per cycle
    // and drops out once it passes the last forwardable stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            age_r  <= {AGE_W{1'b0}};
            lat_r  <= {AGE_W{1'b0}};
        end else if (issue) begin
            busy_r <= 1'b1;
            age_r  <= AGE_W'(FWD_EX);
            lat_r  <= lat_in;
        end else if (busy_r) begin
            if (age_r == AGE_W'(FWD_STAGES)) begin
                busy_r <= 1'b0;
            end else begin
                age_r <= age_r + AGE_W'(1);
            end
        end else begin
            busy_r <= busy_r;
        end
    end

    assign busy = busy_r;
    assign age  = age_r;
    assign lat  = lat_r;

endmodule : id_sb_entry

// File: rtl/id_scoreboard.sv
// ---------------------------------------------------------------------------
// id_scoreboard: ID-stage register scoreboard producing stall/bubble control
// and per-operand forward-stage selects for any forwarding depth.
//   clk, reset                 clock, synchronous active-high reset
//   id_valid, id_flush         real instruction in ID / kill it (no issue)
//   id_rs/_used, id_rt/_used   source operand indices and use flags
//   id_wr_en, id_wr_reg        destination write enable and index
//   id_lat                     stage at which the result becomes forwardable
//   stall, pc_ifid_write       hazard hold, and its inverse for PC/IF_ID
//   bubble                     clear control entering ID_EX
//   fwd_rs_sel, fwd_rt_sel     0 = regfile, k = result of stage k
//   busy_vec                   per-register in-flight bits (debug)
// Optional build macro ID_SCOREBOARD_STATS_EN adds stall_cycles and
// issue_count counters.
// ---------------------------------------------------------------------------
module id_scoreboard
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_AW     = id_pkg::REG_AW,
    parameter int FWD_STAGES = 2,
    parameter int AGE_W      = $clog2(FWD_STAGES + 2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic                id_flush,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic                id_rs_used,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_rt_used,
    input  logic                id_wr_en,
    input  logic [REG_AW-1:0]   id_wr_reg,
    input  logic [AGE_W-1:0]    id_lat,
    output logic                stall,
    output logic                pc_ifid_write,
    output logic                bubble,
    output logic [AGE_W-1:0]    fwd_rs_sel,
    output logic [AGE_W-1:0]    fwd_rt_sel,
`ifdef ID_SCOREBOARD_STATS_EN
    output logic [31:0]         stall_cycles,
    output logic [31:0]         issue_count,
`endif
    output logic [NUM_REGS-1:0] busy_vec
);

    import id_pkg::*;

    logic [NUM_REGS-1:0]            busy_s;
    logic [NUM_REGS-1:0][AGE_W-1:0] age_s;
    logic [NUM_REGS-1:0][AGE_W-1:0] lat_s;
    logic [AGE_W-1:0]               lat_eff_s;
    logic                           rs_live_s;
    logic                           rt_live_s;
    logic                           hazard_rs_s;
    logic                           hazard_rt_s;
    logic                           stall_s;
    logic                           issue_s;

    // Register 0 never holds an in-flight value.
    assign busy_s[0] = 1'b0;
    assign age_s[0]  = {AGE_W{1'b0}};
    assign lat_s[0]  = {AGE_W{1'b0}};

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        id_sb_entry #(
            .FWD_STAGES (FWD_STAGES),
            .AGE_W      (AGE_W)
        ) u_entry (
            .clk    (clk),
            .reset  (reset),
            .issue  (issue_s && (id_wr_reg == REG_AW'(r))),
            .lat_in (lat_eff_s),
            .busy   (busy_s[r]),
            .age    (age_s[r]),
            .lat    (lat_s[r])
        );
    end

    // Latency clamp: a zero latency means "available after EX", anything
    // beyond the forwarding depth is only seen at the last forward stage.
    always_comb begin
        lat_eff_s = id_lat;
        if (id_lat == {AGE_W{1'b0}}) begin
            lat_eff_s = AGE_W'(FWD_EX);
        end else if (id_lat > AGE_W'(FWD_STAGES)) begin
            lat_eff_s = AGE_W'(FWD_STAGES);
        end else begin
            lat_eff_s = id_lat;
        end
    end

    // A source is "live" when it reads a register with an in-flight producer;
    // it is a hazard while that producer has not reached its result stage.
    always_comb begin
        rs_live_s   = id_rs_used && (id_rs != {REG_AW{1'b0}}) && busy_s[id_rs];
        rt_live_s   = id_rt_used && (id_rt != {REG_AW{1'b0}}) && busy_s[id_rt];
        hazard_rs_s = rs_live_s && (age_s[id_rs] < lat_s[id_rs]);
        hazard_rt_s = rt_live_s && (age_s[id_rt] < lat_s[id_rt]);
        // Flush dominates the hazard: a killed instruction never waits.
        stall_s     = id_valid && !id_flush && (hazard_rs_s || hazard_rt_s);
        issue_s     = id_valid && !id_flush && !stall_s && id_wr_en &&
                      (id_wr_reg != {REG_AW{1'b0}});
    end

    // Forward selects follow the producer's current stage directly, so the
    // datapath mux index equals the stage number.
    always_comb begin
        fwd_rs_sel = AGE_W'(FWD_SEL_REGFILE);
        fwd_rt_sel = AGE_W'(FWD_SEL_REGFILE);
        if (rs_live_s) begin
            fwd_rs_sel = age_s[id_rs];
        end else begin
            fwd_rs_sel = AGE_W'(FWD_SEL_REGFILE);
        end
        if (rt_live_s) begin
            fwd_rt_sel = age_s[id_rt];
        end else begin
            fwd_rt_sel = AGE_W'(FWD_SEL_REGFILE);
        end
    end

    assign stall         = stall_s;
    assign pc_ifid_write = !stall_s;
    assign bubble        = stall_s || id_flush;
    assign busy_vec      = busy_s;

`ifdef ID_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] issue_count_r;

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r <= 32'd0;
            issue_count_r  <= 32'd0;
        end else begin
            if (stall_s) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (issue_s) begin
                issue_count_r <= issue_count_r + 32'd1;
            end else begin
                issue_count_r <= issue_count_r;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign issue_count  = issue_count_r;
`endif

endmodule : id_scoreboard

// File: tb/tb_id_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_scoreboard: directed scoreboard bench for id_scoreboard
// (FWD_STAGES=2). Stimulus drives one ID cycle at a time and pushes the
// hand-computed expected outputs; a monitor pops and compares on negedge.
// ---------------------------------------------------------------------------
module tb_id_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int AGE_W    = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                id_valid, id_flush, id_rs_used, id_rt_used, id_wr_en;
    logic [REG_AW-1:0]   id_rs, id_rt, id_wr_reg;
    logic [AGE_W-1:0]    id_lat;
    logic                stall, pc_ifid_write, bubble;
    logic [AGE_W-1:0]    fwd_rs_sel, fwd_rt_sel;
    logic [NUM_REGS-1:0] busy_vec;
`ifdef ID_SCOREBOARD_STATS_EN
    logic [31:0]         stall_cycles, issue_count;
`endif

    id_scoreboard #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .FWD_STAGES(2), .AGE_W(AGE_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_flush      (id_flush),
        .id_rs         (id_rs),
        .id_rs_used    (id_rs_used),
        .id_rt         (id_rt),
        .id_rt_used    (id_rt_used),
        .id_wr_en      (id_wr_en),
        .id_wr_reg     (id_wr_reg),
        .id_lat        (id_lat),
        .stall         (stall),
        .pc_ifid_write (pc_ifid_write),
        .bubble        (bubble),
        .fwd_rs_sel    (fwd_rs_sel),
        .fwd_rt_sel    (fwd_rt_sel),
`ifdef ID_SCOREBOARD_STATS_EN
        .stall_cycles  (stall_cycles),
        .issue_count   (issue_count),
`endif
        .busy_vec      (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        bubble;
        logic [1:0]  rs_sel;
        logic [1:0]  rt_sel;
        logic [31:0] busy;
        bit          chk_stats;
        logic [31:0] stall_cycles;
        logic [31:0] issue_count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: compares every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".stall"},  32'(stall),         32'(e.stall));
            chk({e.name, ".bubble"}, 32'(bubble),        32'(e.bubble));
            chk({e.name, ".pcw"},    32'(pc_ifid_write), 32'(!e.stall));
            chk({e.name, ".rs_sel"}, 32'(fwd_rs_sel),    32'(e.rs_sel));
            chk({e.name, ".rt_sel"}, 32'(fwd_rt_sel),    32'(e.rt_sel));
            chk({e.name, ".busy"},   busy_vec,           e.busy);
`ifdef ID_SCOREBOARD_STATS_EN
            if (e.chk_stats) begin
                chk({e.name, ".stall_cycles"}, stall_cycles, e.stall_cycles);
                chk({e.name, ".issue_count"},  issue_count,  e.issue_count);
            end
`endif
        end
    end

    task automatic drv(input bit v, input bit f, input int rs, input bit rsu,
                       input int rt, input bit rtu, input bit we, input int wr, input int lat);
        id_valid   = v;
        id_flush   = f;
        id_rs      = REG_AW'(rs);
        id_rs_used = rsu;
        id_rt      = REG_AW'(rt);
        id_rt_used = rtu;
        id_wr_en   = we;
        id_wr_reg  = REG_AW'(wr);
        id_lat     = AGE_W'(lat);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic expect_out(input string nm, input bit st, input bit bub, input int rss,
                              input int rts, input logic [31:0] bv, input bit cs = 1'b0,
                              input int sc = 0, input int ic = 0);
        exp_t e;
        e.name = nm; e.stall = st; e.bubble = bub;
        e.rs_sel = 2'(rss); e.rt_sel = 2'(rts); e.busy = bv;
        e.chk_stats = cs; e.stall_cycles = 32'(sc); e.issue_count = 32'(ic);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bit_of(input int r);
        return 32'd1 << r;
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        tick(); tick();
        reset = 1'b0;
        idle();
        expect_out("reset", 1'b0, 1'b0, 0, 0, 32'd0, 1'b1, 0, 0);
        tick();

        // ALU chain: add $8 (lat1) then readers of $8
        drv(1, 0, 0, 0, 0, 0, 1, 8, 1);  expect_out("alu_issue", 0, 0, 0, 0, 32'd0);            tick();
        drv(1, 0, 8, 1, 0, 0, 0, 0, 0);  expect_out("alu_ex",    0, 0, 1, 0, bit_of(8));        tick();
        drv(1, 0, 8, 1, 0, 0, 0, 0, 0);  expect_out("alu_mem",   0, 0, 2, 0, bit_of(8));        tick();
        drv(1, 0, 8, 1, 0, 0, 0, 0, 0);  expect_out("alu_wb",    0, 0, 0, 0, 32'd0);            tick();

        // Load-use: lw $9 (lat2), reader of rt=$9 stalls exactly once
        drv(1, 0, 0, 0, 0, 0, 1, 9, 2);  expect_out("lw_issue",  0, 0, 0, 0, 32'd0);            tick();
        drv(1, 0, 0, 0, 9, 1, 0, 0, 0);  expect_out("lw_stall",  1, 1, 0, 1, bit_of(9));        tick();
        drv(1, 0, 0, 0, 9, 1, 0, 0, 0);  expect_out("lw_go",     0, 0, 0, 2, bit_of(9));        tick();
        idle();                          expect_out("lw_done",   0, 0, 0, 0, 32'd0);            tick();

        // Youngest wins: $10 issued twice back to back
        drv(1, 0, 0, 0, 0, 0, 1, 10, 1); expect_out("yw_first",  0, 0, 0, 0, 32'd0);            tick();
        drv(1, 0, 0, 0, 0, 0, 1, 10, 1); expect_out("yw_second", 0, 0, 0, 0, bit_of(10));       tick();
        drv(1, 0, 10, 1, 0, 0, 0, 0, 0); expect_out("yw_read",   0, 0, 1, 0, bit_of(10));       tick();
        idle();                          expect_out("yw_age2",   0, 0, 0, 0, bit_of(10));       tick();
        idle();                          expect_out("yw_gone",   0, 0, 0, 0, 32'd0);            tick();

        // Latency clamp: lat 3 behaves as 2, lat 0 behaves as 1
        drv(1, 0, 0, 0, 0, 0, 1, 13, 3); expect_out("clamp_hi_iss", 0, 0, 0, 0, 32'd0);         tick();
        drv(1, 0, 13, 1, 0, 0, 0, 0, 0); expect_out("clamp_hi_stl", 1, 1, 1, 0, bit_of(13));    tick();
        drv(1, 0, 13, 1, 0, 0, 0, 0, 0); expect_out("clamp_hi_go",  0, 0, 2, 0, bit_of(13));    tick();
        drv(1, 0, 0, 0, 0, 0, 1, 14, 0); expect_out("clamp_lo_iss", 0, 0, 0, 0, 32'd0);         tick();
        drv(1, 0, 14, 1, 0, 0, 0, 0, 0); expect_out("clamp_lo_rd",  0, 0, 1, 0, bit_of(14));    tick();
        idle();                          expect_out("clamp_lo_a2",  0, 0, 0, 0, bit_of(14));    tick();

        // Zero register never becomes busy or forwarded
        drv(1, 0, 0, 0, 0, 0, 1, 0, 1);  expect_out("zero_issue", 0, 0, 0, 0, 32'd0);           tick();
        drv(1, 0, 0, 1, 0, 1, 0, 0, 0);  expect_out("zero_read",  0, 0, 0, 0, 32'd0);           tick();

        // Flush beats the hazard, and the flushed destination ($15) is not recorded
        drv(1, 0, 0, 0, 0, 0, 1, 11, 2); expect_out("fl_lw",     0, 0, 0, 0, 32'd0);            tick();
        drv(1, 1, 11, 1, 0, 0, 1, 15, 1); expect_out("fl_flush", 0, 1, 1, 0, bit_of(11));       tick();
        idle();                          expect_out("fl_after",  0, 0, 0, 0, bit_of(11));       tick();
        idle();                          expect_out("fl_clear",  0, 0, 0, 0, 32'd0);            tick();

        // A stalled writer issues only once the stall clears
        drv(1, 0, 0, 0, 0, 0, 1, 9, 2);  expect_out("sw_lw",     0, 0, 0, 0, 32'd0);            tick();
        drv(1, 0, 0, 0, 9, 1, 1, 16, 1); expect_out("sw_stall",  1, 1, 0, 1, bit_of(9));        tick();
        drv(1, 0, 0, 0, 9, 1, 1, 16, 1); expect_out("sw_go",     0, 0, 0, 2, bit_of(9));        tick();
        idle();                          expect_out("sw_issued", 0, 0, 0, 0, bit_of(16));       tick();
        idle();                          expect_out("sw_age2",   0, 0, 0, 0, bit_of(16));       tick();
        idle();                          expect_out("sw_clear",  0, 0, 0, 0, 32'd0);            tick();

        // Three load-use pairs from a fresh reset: 3 stalls, 6 issues
        reset = 1'b1; idle(); tick(); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] prev20;
            prev20 = (k == 0) ? 32'd0 : bit_of(20);
            drv(1, 0, 0, 0, 0, 0, 1, 18, 2);  expect_out("pair_lw",    0, 0, 0, 0, prev20);            tick();
            drv(1, 0, 18, 1, 0, 0, 1, 20, 1); expect_out("pair_stall", 1, 1, 1, 0, bit_of(18) | prev20); tick();
            drv(1, 0, 18, 1, 0, 0, 1, 20, 1); expect_out("pair_go",    0, 0, 2, 0, bit_of(18));        tick();
        end
        idle();                           expect_out("pair_stats", 0, 0, 0, 0, bit_of(20), 1'b1, 3, 6); tick();

        // Reset asserted while a stall is showing
        drv(1, 0, 0, 0, 0, 0, 1, 18, 2);  expect_out("rst_lw",     0, 0, 0, 0, bit_of(20));        tick();
        drv(1, 0, 18, 1, 0, 0, 0, 0, 0);
        reset = 1'b1;                     expect_out("rst_stall",  1, 1, 1, 0, bit_of(18), 1'b1, 3, 7); tick();
        reset = 1'b0;                     expect_out("rst_after",  0, 0, 0, 0, 32'd0, 1'b1, 0, 0); tick();
        idle();

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) tick();
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_id_scoreboard
